// File: rtl/reorder_buffer_mc_if.sv
// reorder_buffer_mc_if: allocation, writeback, commit, query and flush signals of the reorder buffer.
interface reorder_buffer_mc_if #(
  parameter int DEPTH_BIT = 4,
  parameter int WB_PORTS  = 2,
  parameter int COMMIT_W  = 2
);
  logic                          rdy_in;
  logic                          alloc_valid;
  logic                          alloc_done;
  logic [31:0]                   alloc_value;
  logic [4:0]                    alloc_rd;
  logic [1:0]                    alloc_type;
  logic [31:0]                   alloc_pc;
  logic                          alloc_pred;
  logic [DEPTH_BIT-1:0]          alloc_id;
  logic                          rob_full;
  logic [DEPTH_BIT:0]            rob_count;
  logic [WB_PORTS-1:0]           wb_valid;
  logic [WB_PORTS*DEPTH_BIT-1:0] wb_id;
  logic [WB_PORTS*32-1:0]        wb_val;
  logic [WB_PORTS-1:0]           wb_taken;
  logic [COMMIT_W-1:0]           commit_valid;
  logic [COMMIT_W*5-1:0]         commit_rd;
  logic [COMMIT_W*32-1:0]        commit_val;
  logic [COMMIT_W*DEPTH_BIT-1:0] commit_id;
  logic [COMMIT_W*2-1:0]         commit_type;
  logic [DEPTH_BIT-1:0]          head_id;
  logic                          head_is_mem;
  logic [DEPTH_BIT-1:0]          q1_id, q2_id;
  logic                          q1_ready, q2_ready;
  logic [31:0]                   q1_val, q2_val;
  logic                          flush_out;
  logic [31:0]                   flush_pc;
  modport master (
    output rdy_in, alloc_valid, alloc_done, alloc_value, alloc_rd, alloc_type, alloc_pc, alloc_pred,
           wb_valid, wb_id, wb_val, wb_taken, q1_id, q2_id,
    input  alloc_id, rob_full, rob_count, commit_valid, commit_rd, commit_val, commit_id, commit_type,
           head_id, head_is_mem, q1_ready, q2_ready, q1_val, q2_val, flush_out, flush_pc
  );
  modport slave (
    input  rdy_in, alloc_valid, alloc_done, alloc_value, alloc_rd, alloc_type, alloc_pc, alloc_pred,
           wb_valid, wb_id, wb_val, wb_taken, q1_id, q2_id,
    output alloc_id, rob_full, rob_count, commit_valid, commit_rd, commit_val, commit_id, commit_type,
           head_id, head_is_mem, q1_ready, q2_ready, q1_val, q2_val, flush_out, flush_pc
  );
endinterface

// File: rtl/reorder_buffer_mc.sv
// reorder_buffer_mc: in-order allocate, out-of-order writeback, up to two in-order commits, registered mispredict flush.
// Define ROB_BYPASS_EN to let operand queries see same-cycle writeback and allocation results.
module reorder_buffer_mc #(
  parameter int DEPTH_BIT = 4,
  parameter int WB_PORTS  = 2,
  parameter int COMMIT_W  = 2
) (
  input logic               clk_in,
  input logic               rst_in,
  reorder_buffer_mc_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_BIT;
  localparam int CW = DEPTH_BIT + 1;
  typedef logic [DEPTH_BIT-1:0] idx_t;
  typedef logic [CW-1:0] cnt_t;

  idx_t             head_q, head_d, tail_q, tail_d, h1;
  cnt_t             count_q, count_d;
  logic [DEPTH-1:0] busy_q, busy_d, done_q, done_d, pred_q, taken_q;
  logic             flush_q, flush_d;
  logic [31:0]      flush_pc_q, flush_pc_d;
  logic [31:0]      value_q [DEPTH];
  logic [31:0]      pc_q [DEPTH];
  logic [4:0]       rd_q [DEPTH];
  logic [1:0]       type_q [DEPTH];
  logic             live, acc, c0, c1, mis0, mis1;
  logic [1:0]       cv;
  logic [WB_PORTS-1:0] wb_hit;
  idx_t             wb_idx [WB_PORTS];
  idx_t             sidx [COMMIT_W];
  idx_t             qid [2];
  logic [32:0]      qres [2];

  assign live = bus.rdy_in && !flush_q;
  assign acc  = live && bus.alloc_valid && count_q != cnt_t'(DEPTH);
  assign h1   = head_q + 1'b1;
  assign mis0 = type_q[head_q] == 2'b10 && taken_q[head_q] != pred_q[head_q];
  assign mis1 = type_q[h1] == 2'b10 && taken_q[h1] != pred_q[h1];
  assign c0   = live && busy_q[head_q] && done_q[head_q];
  // type bit0 marks Store/Load; only one memory op may retire per cycle
  assign c1   = COMMIT_W == 2 && c0 && busy_q[h1] && done_q[h1] && count_q > cnt_t'(1) && !mis0
                && !(type_q[head_q][0] && type_q[h1][0]);
  assign cv   = {c1, c0};

  always_comb begin
    for (int k = 0; k < WB_PORTS; k++) begin
      wb_idx[k] = bus.wb_id[k*DEPTH_BIT +: DEPTH_BIT];
      wb_hit[k] = live && bus.wb_valid[k] && busy_q[bus.wb_id[k*DEPTH_BIT +: DEPTH_BIT]];
    end
  end

  always_comb begin
    busy_d     = busy_q;
    done_d     = done_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    flush_d    = flush_q;
    flush_pc_d = flush_pc_q;
    if (bus.rdy_in && flush_q) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      flush_d = 1'b0;
    end else if (live) begin
      for (int k = 0; k < WB_PORTS; k++)
        if (wb_hit[k]) done_d[wb_idx[k]] = 1'b1;
      if (acc) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = bus.alloc_done;
      end
      if (c0) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
      end
      if (c1) begin
        busy_d[h1] = 1'b0;
        done_d[h1] = 1'b0;
      end
      head_d  = head_q + idx_t'(c0) + idx_t'(c1);
      tail_d  = tail_q + idx_t'(acc);
      count_d = count_q + cnt_t'(acc) - cnt_t'(c0) - cnt_t'(c1);
      if (c0 && mis0) begin
        flush_d    = 1'b1;
        flush_pc_d = taken_q[head_q] ? value_q[head_q] : pc_q[head_q] + 32'd4;
      end else if (c1 && mis1) begin
        flush_d    = 1'b1;
        flush_pc_d = taken_q[h1] ? value_q[h1] : pc_q[h1] + 32'd4;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      done_q     <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // payload needs no reset: it is only observed through busy/done
  always_ff @(posedge clk_in) begin
    if (acc) begin
      value_q[tail_q] <= bus.alloc_value;
      pc_q[tail_q]    <= bus.alloc_pc;
      rd_q[tail_q]    <= bus.alloc_rd;
      type_q[tail_q]  <= bus.alloc_type;
      pred_q[tail_q]  <= bus.alloc_pred;
      taken_q[tail_q] <= 1'b0;
    end
    for (int k = 0; k < WB_PORTS; k++)
      if (wb_hit[k]) begin
        value_q[wb_idx[k]] <= bus.wb_val[k*32 +: 32];
        taken_q[wb_idx[k]] <= bus.wb_taken[k];
      end
  end

  assign bus.alloc_id     = tail_q;
  assign bus.rob_full     = count_q == cnt_t'(DEPTH) || flush_q;
  assign bus.rob_count    = count_q;
  assign bus.commit_valid = cv[COMMIT_W-1:0];
  assign bus.head_id      = head_q;
  assign bus.head_is_mem  = busy_q[head_q] && type_q[head_q][0];
  assign bus.flush_out    = flush_q;
  assign bus.flush_pc     = flush_pc_q;

  always_comb begin
    for (int s = 0; s < COMMIT_W; s++) begin
      sidx[s] = head_q + idx_t'(s);
      bus.commit_rd[s*5 +: 5]                 = type_q[sidx[s]][0] == type_q[sidx[s]][1] ? rd_q[sidx[s]] : 5'd0;
      bus.commit_val[s*32 +: 32]              = value_q[sidx[s]];
      bus.commit_id[s*DEPTH_BIT +: DEPTH_BIT] = sidx[s];
      bus.commit_type[s*2 +: 2]               = type_q[sidx[s]];
    end
  end

  assign qid[0] = bus.q1_id;
  assign qid[1] = bus.q2_id;

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      qres[n] = {done_q[qid[n]], value_q[qid[n]]};
`ifdef ROB_BYPASS_EN
      if (!done_q[qid[n]]) begin
        if (bus.alloc_valid && bus.alloc_done && qid[n] == tail_q) qres[n] = {1'b1, bus.alloc_value};
        for (int k = 0; k < WB_PORTS; k++)
          if (bus.wb_valid[k] && bus.wb_id[k*DEPTH_BIT +: DEPTH_BIT] == qid[n])
            qres[n] = {1'b1, bus.wb_val[k*32 +: 32]};
      end
`endif
    end
  end

  assign bus.q1_ready = qres[0][32];
  assign bus.q1_val   = qres[0][31:0];
  assign bus.q2_ready = qres[1][32];
  assign bus.q2_val   = qres[1][31:0];
endmodule

// File: tb/tb_reorder_buffer_mc.sv
// tb_reorder_buffer_mc: directed stimulus with a queue-based program-order model checked every cycle.
module tb_reorder_buffer_mc;
  localparam int DB = 4, WB = 2, CWD = 2, DEPTH = 16;
`ifdef ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_mc_if #(.DEPTH_BIT(DB), .WB_PORTS(WB), .COMMIT_W(CWD)) bus ();
  reorder_buffer_mc #(.DEPTH_BIT(DB), .WB_PORTS(WB), .COMMIT_W(CWD)) dut (
    .clk_in(clk), .rst_in(rst_n), .bus(bus)
  );

  int n_checks = 0, n_pass = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  typedef struct {
    int id; bit done; logic [31:0] val; logic [4:0] rd; logic [1:0] typ;
    logic [31:0] pc; bit pred; bit taken;
  } ent_t;

  ent_t mq[$];
  int mtail = 0;
  bit mflush = 1'b0;
  logic [31:0] mfpc = '0;

  function automatic bit is_mem(logic [1:0] t);
    return t == 2'b01 || t == 2'b11;
  endfunction
  function automatic bit mispred(ent_t e);
    return e.typ == 2'b10 && e.taken != e.pred;
  endfunction

  function automatic logic [32:0] mquery(int qid);
    logic [32:0] r = '0;
    foreach (mq[i]) if (mq[i].id == qid && mq[i].done) r = {1'b1, mq[i].val};
    if (BYP && !r[32]) begin
      if (bus.alloc_valid && bus.alloc_done && qid == mtail) r = {1'b1, bus.alloc_value};
      for (int k = 0; k < WB; k++)
        if (bus.wb_valid[k] && int'(bus.wb_id[k*DB +: DB]) == qid) r = {1'b1, bus.wb_val[k*32 +: 32]};
    end
    return r;
  endfunction

  int ncom, presize;
  bit fl;
  logic [31:0] fpc;
  logic [32:0] qr;
  ent_t e, ne;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mtail = 0;
      mflush = 1'b0;
      mfpc = '0;
    end
    ncom = 0;
    if (rst_n && bus.rdy_in && !mflush && mq.size() > 0 && mq[0].done) begin
      ncom = 1;
      if (mq.size() > 1 && mq[1].done && !mispred(mq[0]) && !(is_mem(mq[0].typ) && is_mem(mq[1].typ)))
        ncom = 2;
    end
    chk("commit_valid", bus.commit_valid, (ncom == 2) ? 2'b11 : (ncom == 1) ? 2'b01 : 2'b00);
    for (int s = 0; s < ncom; s++) begin
      e = mq[s];
      chk("commit_id", bus.commit_id[s*DB +: DB], e.id);
      chk("commit_val", bus.commit_val[s*32 +: 32], e.val);
      chk("commit_type", bus.commit_type[s*2 +: 2], e.typ);
      chk("commit_rd", bus.commit_rd[s*5 +: 5], (e.typ == 2'b00 || e.typ == 2'b11) ? e.rd : 5'd0);
    end
    chk("alloc_id", bus.alloc_id, mtail);
    chk("rob_count", bus.rob_count, mq.size());
    chk("rob_full", bus.rob_full, mq.size() == DEPTH || mflush);
    chk("head_id", bus.head_id, (mtail - mq.size() + DEPTH) % DEPTH);
    chk("head_is_mem", bus.head_is_mem, mq.size() > 0 && is_mem(mq[0].typ));
    chk("flush_out", bus.flush_out, mflush);
    chk("flush_pc", bus.flush_pc, mfpc);
    qr = mquery(int'(bus.q1_id));
    chk("q1_ready", bus.q1_ready, qr[32]);
    if (qr[32]) chk("q1_val", bus.q1_val, qr[31:0]);
    qr = mquery(int'(bus.q2_id));
    chk("q2_ready", bus.q2_ready, qr[32]);
    if (qr[32]) chk("q2_val", bus.q2_val, qr[31:0]);
    if (rst_n && bus.rdy_in) begin
      if (mflush) begin
        mq.delete();
        mtail = 0;
        mflush = 1'b0;
      end else begin
        presize = mq.size();
        fl = 1'b0;
        fpc = '0;
        for (int s = 0; s < ncom; s++)
          if (!fl && mispred(mq[s])) begin
            fl = 1'b1;
            fpc = mq[s].taken ? mq[s].val : mq[s].pc + 32'd4;
          end
        for (int k = 0; k < WB; k++)
          if (bus.wb_valid[k])
            foreach (mq[i])
              if (mq[i].id == int'(bus.wb_id[k*DB +: DB])) begin
                mq[i].done = 1'b1;
                mq[i].val = bus.wb_val[k*32 +: 32];
                mq[i].taken = bus.wb_taken[k];
              end
        repeat (ncom) void'(mq.pop_front());
        if (bus.alloc_valid && presize < DEPTH) begin
          ne = '{id: mtail, done: bus.alloc_done, val: bus.alloc_value, rd: bus.alloc_rd,
                 typ: bus.alloc_type, pc: bus.alloc_pc, pred: bus.alloc_pred, taken: 1'b0};
          mq.push_back(ne);
          mtail = (mtail + 1) % DEPTH;
        end
        if (fl) begin
          mflush = 1'b1;
          mfpc = fpc;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(logic [1:0] t, logic d, logic [31:0] v, logic [4:0] rd, logic [31:0] pc, logic p);
    bus.alloc_valid = 1'b1;
    bus.alloc_type  = t;
    bus.alloc_done  = d;
    bus.alloc_value = v;
    bus.alloc_rd    = rd;
    bus.alloc_pc    = pc;
    bus.alloc_pred  = p;
    step();
    bus.alloc_valid = 1'b0;
    #1;
  endtask

  task automatic wb2(logic [1:0] vld, int i0, logic [31:0] v0, int i1, logic [31:0] v1, logic [1:0] tk);
    bus.wb_valid = vld;
    bus.wb_id    = {4'(i1), 4'(i0)};
    bus.wb_val   = {v1, v0};
    bus.wb_taken = tk;
    step();
    bus.wb_valid = '0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    bus.rdy_in = 1'b1;
    bus.alloc_valid = 1'b0; bus.alloc_done = 1'b0; bus.alloc_value = '0; bus.alloc_rd = '0;
    bus.alloc_type = '0; bus.alloc_pc = '0; bus.alloc_pred = 1'b0;
    bus.wb_valid = '0; bus.wb_id = '0; bus.wb_val = '0; bus.wb_taken = '0;
    bus.q1_id = '0; bus.q2_id = '0;
    do_reset();
    // reset while entries are busy
    for (int i = 0; i < 3; i++) alloc(2'b00, 1'b0, 32'h0, 5'(i + 1), 32'h0, 1'b0);
    chk("t1_count_before", bus.rob_count, 3);
    rst_n = 1'b0;
    #1;
    chk("t1_count", bus.rob_count, 0);
    chk("t1_commit", bus.commit_valid, 0);
    chk("t1_flush", bus.flush_out, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t1_alloc_id", bus.alloc_id, 0);
    // fill, overflow, drain two per cycle with wrap
    for (int i = 0; i < DEPTH; i++) alloc(2'b00, 1'b0, 32'h0, 5'(i + 1), 32'(i * 4), 1'b0);
    chk("t2_full", bus.rob_full, 1);
    chk("t2_count", bus.rob_count, 16);
    alloc(2'b00, 1'b1, 32'hEE, 5'd9, 32'h0, 1'b0);
    chk("t2_count_after17", bus.rob_count, 16);
    chk("t2_alloc_id_wrap", bus.alloc_id, 0);
    for (int j = 0; j < 8; j++) begin
      wb2(2'b11, 2 * j, 32'(32'h100 + 2 * j), 2 * j + 1, 32'(32'h101 + 2 * j), 2'b00);
      if (j == 0) begin
        chk("t2_dual_commit", bus.commit_valid, 2'b11);
        chk("t2_commit_ids", bus.commit_id, 8'h10);
        chk("t2_commit_val0", bus.commit_val[31:0], 32'h100);
      end
    end
    step();
    step();
    chk("t2_drained", bus.rob_count, 0);
    chk("t2_head_wrap", bus.head_id, 0);
    // store + load: one memory op per cycle
    alloc(2'b01, 1'b0, 32'h0, 5'd3, 32'h0, 1'b0);
    alloc(2'b11, 1'b1, 32'h33, 5'd7, 32'h0, 1'b0);
    wb2(2'b01, 0, 32'h30, 0, 32'h0, 2'b00);
    chk("t3_slot0_only", bus.commit_valid, 2'b01);
    chk("t3_id0", bus.commit_id[3:0], 0);
    chk("t3_store_rd", bus.commit_rd[4:0], 0);
    step();
    chk("t3_next", bus.commit_valid, 2'b01);
    chk("t3_id1", bus.commit_id[3:0], 1);
    chk("t3_load_rd", bus.commit_rd[4:0], 7);
    chk("t3_load_val", bus.commit_val[31:0], 32'h33);
    step();
    chk("t3_empty", bus.rob_count, 0);
    // mispredicted branch
    do_reset();
    alloc(2'b10, 1'b0, 32'h0, 5'd0, 32'h200, 1'b0);
    alloc(2'b00, 1'b1, 32'h77, 5'd5, 32'h204, 1'b0);
    wb2(2'b01, 0, 32'h1000, 0, 32'h0, 2'b01);
    chk("t4_commit", bus.commit_valid, 2'b01);
    chk("t4_type", bus.commit_type[1:0], 2'b10);
    step();
    chk("t4_flush", bus.flush_out, 1);
    chk("t4_flush_pc", bus.flush_pc, 32'h1000);
    chk("t4_no_commit", bus.commit_valid, 0);
    chk("t4_full", bus.rob_full, 1);
    step();
    chk("t4_flush_clr", bus.flush_out, 0);
    chk("t4_count", bus.rob_count, 0);
    chk("t4_tail", bus.alloc_id, 0);
    // same-id writeback collision and writeback to a free entry
    for (int i = 0; i < 4; i++) alloc(2'b00, 1'b0, 32'h0, 5'(i + 1), 32'h0, 1'b0);
    wb2(2'b11, 3, 32'hA, 3, 32'hB, 2'b00);
    wb2(2'b11, 0, 32'h10, 1, 32'h11, 2'b00);
    bus.q2_id = 4'd5;
    wb2(2'b11, 2, 32'h12, 5, 32'hDEAD, 2'b00);
    chk("t5_dual", bus.commit_valid, 2'b11);
    chk("t5_ids", bus.commit_id, 8'h32);
    chk("t5_high_ch_wins", bus.commit_val[63:32], 32'hB);
    chk("t5_free_wb_ignored", bus.q2_ready, 0);
    chk("t5_count", bus.rob_count, 2);
    step();
    chk("t5_empty", bus.rob_count, 0);
    bus.q2_id = '0;
    // query bypass and freeze
    do_reset();
    for (int i = 0; i < 3; i++) alloc(2'b00, 1'b0, 32'h0, 5'(i + 1), 32'h0, 1'b0);
    bus.q1_id = 4'd2;
    bus.wb_valid = 2'b01; bus.wb_id = 8'h02; bus.wb_val = {32'h0, 32'h55}; bus.wb_taken = '0;
    #1;
    chk("t6_byp_ready", bus.q1_ready, BYP);
    chk("t6_byp_val", bus.q1_val, BYP ? 32'h55 : 32'h0);
    step();
    bus.wb_valid = '0;
    #1;
    chk("t6_ready", bus.q1_ready, 1);
    chk("t6_val", bus.q1_val, 32'h55);
    bus.rdy_in = 1'b0;
    bus.alloc_valid = 1'b1; bus.alloc_done = 1'b1;
    bus.wb_valid = 2'b01; bus.wb_id = 8'h00; bus.wb_val = {32'h0, 32'h9};
    #1;
    chk("t7_frozen_commit", bus.commit_valid, 0);
    step();
    bus.rdy_in = 1'b1;
    bus.alloc_valid = 1'b0;
    bus.wb_valid = '0;
    bus.q1_id = '0;
    #1;
    chk("t7_count", bus.rob_count, 3);
    chk("t7_tail", bus.alloc_id, 3);
    chk("t7_no_wb", bus.q1_ready, 0);
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
